exe_issue_scheduler: RTL and testbench
======================================

Name: exe_issue_scheduler

Overview:
- Issue controller between decode and the multi-latency execute stage (1-cycle ALU, 4-cycle MUL).
- Holds a reservation table of in-flight instructions indexed by cycles-to-completion.
- Grants issue only when there is no RAW hazard, no collision on the single exe->mem result slot, and no out-of-order completion.
- Presents the retiring entry to the mem stage.

Parameters:
- MAX_STAGES, 4, table depth; must be >= the largest exe_stages value used.
- REG_W, 5, register address width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode holds a valid instruction
- issue_rs1_i  in  REG_W  source register 1
- issue_rs2_i  in  REG_W  source register 2
- issue_uses_rs2_i  in  1  rs2 is read (R/S/B types)
- issue_rd_i  in  REG_W  destination register
- issue_we_i  in  1  instruction writes rd
- issue_stages_i  in  3  execute latency L
- flush_i  in  1  branch-taken flush of all in-flight work
- downstream_stall_i  in  1  mem stage cannot accept; freezes the table
- issue_fire_o  out  1  instruction accepted this cycle
- stall_o  out  1  issue_valid_i && !issue_fire_o
- stall_raw_o  out  1  stall cause: RAW
- stall_struct_o  out  1  stall cause: slot/order conflict
- complete_valid_o  out  1  entry finishes execute this cycle
- complete_rd_o  out  REG_W  rd of the completing entry
- complete_we_o  out  1  we of the completing entry
- inflight_cnt_o  out  3  number of valid entries
- busy_o  out  1  inflight_cnt_o != 0

Behaviour:
- Table: ent[1..MAX_STAGES], each entry is {valid, rd, we}. ent[i] completes i cycles from now; ent[1] completes this cycle.
- Reset (async, rstn_i=0): all ent invalid.
  - All outputs 0; stall_o = 0 only when issue_valid_i = 0 (it is combinational).
- Effective latency Leff:
  - issue_stages_i = 0 → Leff = 1.
  - issue_stages_i > MAX_STAGES → Leff = MAX_STAGES.
- Hazard match: ent valid && we && rd != 0 && rd == rs.
  - rs1 is always checked; rs2 is checked only if issue_uses_rs2_i.
- raw = hazard match on any ent[1..MAX_STAGES].
- struct = any ent[j].valid for j in Leff+1..MAX_STAGES.
  - Covers both a slot collision and a shorter instruction overtaking an older longer one.
- issue_fire_o = issue_valid_i && !raw && !struct && !downstream_stall_i && !flush_i.
- stall_raw_o = issue_valid_i && raw.
- stall_struct_o = issue_valid_i && struct && !raw (RAW has priority in reporting).
- complete_* are combinational from ent[1].
- Clock edge, in priority order:
  1. flush_i → all ent invalid; no issue. Flush wins over downstream_stall_i.
  2. downstream_stall_i → table held; complete_* remain stable.
  3. Otherwise shift: ent[i] <= ent[i+1], ent[MAX_STAGES] <= invalid. If issue_fire_o, ent[Leff] <= {1, issue_rd_i, issue_we_i}.
- Latency: issue accepted in cycle t with no freeze → complete_valid_o in cycle t+Leff. Each frozen cycle adds one.
- Back-to-back: after a 1-cycle instruction, the next cycle may issue any latency.
  - Issue of L=1 at t+1 after L=4 at t is blocked (struct) until the MUL reaches ent[1].
- inflight_cnt_o is the popcount of ent valids, registered with the table.
- Entries with we=0 (stores, branches) occupy slots but never cause RAW.

Optional Feature:
- Macro TARTARUGA_EXE_FWD_EN.
- Defined: hazard matches against ent[1] are ignored, since the completing result is forwarded from exe->mem to the issuing instruction. Only ent[2..MAX_STAGES] matches stall.
- Undefined: any matching entry, including ent[1], stalls.

Test Plan:
- Reset, then ADD L=1 rd=5 at t → complete_valid_o=1, complete_rd_o=5 at t+1; inflight_cnt_o returns to 0 at t+2.
- MUL L=4 rd=7 at t, then an independent ADD L=1 rd=3 offered at t+1 → stall_struct_o=1 for t+1..t+3. ADD fires at t+4 (MUL in ent[1]) and completes at t+5, in order.
- MUL L=4 rd=9, then ADD rs1=9:
  - Without FWD_EN: stall_raw_o=1 through t+4; fire at t+5.
  - With FWD_EN: fire at t+4.
- Instruction with rd=0 we=1, followed by a reader of x0 → no RAW stall. Also: an ADD with rs2=9 and issue_uses_rs2_i=0 while rd=9 is in flight → no stall.
- MUL in flight at ent[3], then downstream_stall_i=1 for 2 cycles → table frozen; completion slips by 2 cycles; issue_fire_o=0 during the freeze.
- Two entries in flight, flush_i=1 together with issue_valid_i → next cycle inflight_cnt_o=0 and the offered instruction was not accepted. Also: rstn_i low mid-MUL → immediate clear, complete_valid_o=0.

Source files
------------

// File: rtl/exe_issue_scheduler_if.sv
// Decode/mem-facing bundle of the execute issue scheduler.
// Groups the issue request, control and completion signals behind master/slave modports.
interface exe_issue_scheduler_if #(
  parameter int unsigned REG_W = 5
);
  logic             issue_valid_i;
  logic [REG_W-1:0] issue_rs1_i;
  logic [REG_W-1:0] issue_rs2_i;
  logic             issue_uses_rs2_i;
  logic [REG_W-1:0] issue_rd_i;
  logic             issue_we_i;
  logic [2:0]       issue_stages_i;
  logic             flush_i;
  logic             downstream_stall_i;
  logic             issue_fire_o;
  logic             stall_o;
  logic             stall_raw_o;
  logic             stall_struct_o;
  logic             complete_valid_o;
  logic [REG_W-1:0] complete_rd_o;
  logic             complete_we_o;
  logic [2:0]       inflight_cnt_o;
  logic             busy_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_uses_rs2_i,
           issue_rd_i, issue_we_i, issue_stages_i, flush_i, downstream_stall_i,
    input  issue_fire_o, stall_o, stall_raw_o, stall_struct_o,
           complete_valid_o, complete_rd_o, complete_we_o, inflight_cnt_o, busy_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_uses_rs2_i,
           issue_rd_i, issue_we_i, issue_stages_i, flush_i, downstream_stall_i,
    output issue_fire_o, stall_o, stall_raw_o, stall_struct_o,
           complete_valid_o, complete_rd_o, complete_we_o, inflight_cnt_o, busy_o
  );
endinterface

// File: rtl/exe_issue_scheduler.sv
// Issue scheduler for the multi-latency execute stage: reservation table indexed by cycles-to-completion.
// Optional macro TARTARUGA_EXE_FWD_EN: ignore RAW matches on the completing entry (ent[1]), which is forwarded.
module exe_issue_scheduler #(
  parameter int unsigned MAX_STAGES = 4,
  parameter int unsigned REG_W      = 5
) (
  input logic               clk_i,
  input logic               rstn_i,
  exe_issue_scheduler_if.slave bus
);
`ifdef TARTARUGA_EXE_FWD_EN
  localparam int unsigned FIRST_CHK = 2;
`else
  localparam int unsigned FIRST_CHK = 1;
`endif
  localparam int unsigned CNT_W = 3;

  logic [MAX_STAGES:1] vld_q, vld_d;
  logic [MAX_STAGES:1] we_q, we_d;
  logic [REG_W-1:0]    rd_q [1:MAX_STAGES];
  logic [REG_W-1:0]    rd_d [1:MAX_STAGES];
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  int unsigned leff;
  int unsigned n_vld;
  logic        raw;
  logic        struct_hz;
  logic        fire;

  // Effective latency clamped into the table range
  always_comb begin
    leff = 1;
    if (bus.issue_stages_i == 3'd0) begin
      leff = 1;
    end else if (32'(bus.issue_stages_i) > MAX_STAGES) begin
      leff = MAX_STAGES;
    end else begin
      leff = 32'(bus.issue_stages_i);
    end
  end

  // Hazard detection: RAW on any live writer, struct on any entry completing after us
  always_comb begin
    raw       = 1'b0;
    struct_hz = 1'b0;
    for (int unsigned i = 1; i <= MAX_STAGES; i++) begin
      if (i >= FIRST_CHK && vld_q[i] && we_q[i] && rd_q[i] != '0 &&
          (rd_q[i] == bus.issue_rs1_i ||
           (bus.issue_uses_rs2_i && rd_q[i] == bus.issue_rs2_i))) begin
        raw = 1'b1;
      end
      if (i > leff && vld_q[i]) begin
        struct_hz = 1'b1;
      end
    end
  end

  assign fire = bus.issue_valid_i && !raw && !struct_hz &&
                !bus.downstream_stall_i && !bus.flush_i;

  // Next table: flush beats freeze beats shift-and-insert
  always_comb begin
    vld_d = vld_q;
    we_d  = we_q;
    rd_d  = rd_q;
    if (bus.flush_i) begin
      vld_d = '0;
    end else if (!bus.downstream_stall_i) begin
      for (int unsigned i = 1; i < MAX_STAGES; i++) begin
        vld_d[i] = vld_q[i+1];
        we_d[i]  = we_q[i+1];
        rd_d[i]  = rd_q[i+1];
      end
      vld_d[MAX_STAGES] = 1'b0;
      for (int unsigned i = 1; i <= MAX_STAGES; i++) begin
        if (fire && i == leff) begin
          vld_d[i] = 1'b1;
          we_d[i]  = bus.issue_we_i;
          rd_d[i]  = bus.issue_rd_i;
        end
      end
    end
  end

  always_comb begin
    n_vld = 0;
    for (int unsigned i = 1; i <= MAX_STAGES; i++) begin
      n_vld = n_vld + 32'(vld_d[i]);
    end
    cnt_d = CNT_W'(n_vld);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
      we_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 1; i <= MAX_STAGES; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      cnt_q <= cnt_d;
      for (int unsigned i = 1; i <= MAX_STAGES; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  assign bus.issue_fire_o     = fire;
  assign bus.stall_o          = bus.issue_valid_i && !fire;
  assign bus.stall_raw_o      = bus.issue_valid_i && raw;
  assign bus.stall_struct_o   = bus.issue_valid_i && struct_hz && !raw;
  assign bus.complete_valid_o = vld_q[1];
  assign bus.complete_rd_o    = rd_q[1];
  assign bus.complete_we_o    = we_q[1];
  assign bus.inflight_cnt_o   = cnt_q;
  assign bus.busy_o           = cnt_q != '0;
endmodule

// File: tb/tb_exe_issue_scheduler.sv
// Bench for exe_issue_scheduler: directed latency scenarios plus random traffic against an
// in-flight-list reference model (each instruction tracked by its remaining cycles).
module tb_exe_issue_scheduler;
  localparam int MAX_ST = 4;
`ifdef TARTARUGA_EXE_FWD_EN
  localparam int MIN_REM = 2;
  localparam bit FWD = 1'b1;
`else
  localparam int MIN_REM = 1;
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int rd;
    bit we;
    int rem;
  } inst_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  inst_t q[$];

  exe_issue_scheduler_if #(.REG_W(5)) bus();

  exe_issue_scheduler #(.MAX_STAGES(MAX_ST), .REG_W(5)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance the model at posedge
  task automatic step(input bit v, input int rs1, input int rs2, input bit u, input int rd,
                      input bit we, input int stg, input bit fl, input bit ds,
                      output bit f_got, output bit cv_got);
    int  leff;
    bit  raw, st, cv, cwe, fire;
    int  crd;
    inst_t nq[$];
    @(negedge clk);
    bus.issue_valid_i      = v;
    bus.issue_rs1_i        = 5'(rs1);
    bus.issue_rs2_i        = 5'(rs2);
    bus.issue_uses_rs2_i   = u;
    bus.issue_rd_i         = 5'(rd);
    bus.issue_we_i         = we;
    bus.issue_stages_i     = 3'(stg);
    bus.flush_i            = fl;
    bus.downstream_stall_i = ds;
    #1;
    leff = (stg == 0) ? 1 : ((stg > MAX_ST) ? MAX_ST : stg);
    raw = 0; st = 0; cv = 0; cwe = 0; crd = 0;
    foreach (q[k]) begin
      if (q[k].we && q[k].rd != 0 && q[k].rem >= MIN_REM &&
          (q[k].rd == rs1 || (u && q[k].rd == rs2))) raw = 1;
      if (q[k].rem > leff) st = 1;
      if (q[k].rem == 1) begin
        cv = 1; crd = q[k].rd; cwe = q[k].we;
      end
    end
    fire = v && !raw && !st && !ds && !fl;
    check("fire", 32'(bus.issue_fire_o), 32'(fire));
    check("stall", 32'(bus.stall_o), 32'(v && !fire));
    check("stall_raw", 32'(bus.stall_raw_o), 32'(v && raw));
    check("stall_struct", 32'(bus.stall_struct_o), 32'(v && st && !raw));
    check("complete_valid", 32'(bus.complete_valid_o), 32'(cv));
    if (cv) begin
      check("complete_rd", 32'(bus.complete_rd_o), 32'(crd));
      check("complete_we", 32'(bus.complete_we_o), 32'(cwe));
    end
    check("inflight_cnt", 32'(bus.inflight_cnt_o), 32'(q.size()));
    check("busy", 32'(bus.busy_o), 32'(q.size() != 0));
    f_got  = bus.issue_fire_o;
    cv_got = bus.complete_valid_o;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else if (!ds) begin
      foreach (q[k]) if (q[k].rem > 1) nq.push_back('{rd: q[k].rd, we: q[k].we, rem: q[k].rem - 1});
      if (fire) nq.push_back('{rd: rd, we: we, rem: leff});
      q = nq;
    end
  endtask

  task automatic idle(input int n);
    bit f, c;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, f, c);
  endtask

  // Reset asserted mid-cycle clears everything immediately
  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.issue_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.downstream_stall_i = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_complete_valid", 32'(bus.complete_valid_o), 32'd0);
    check("rst_cnt", 32'(bus.inflight_cnt_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    q.delete();
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  // Offer an instruction until it fires; returns the number of stalled cycles
  task automatic offer(input int rs1, input int rs2, input bit u, input int rd, input int stg,
                       output int waited);
    bit f, c;
    waited = 0;
    f = 0;
    while (!f && waited < 12) begin
      step(1, rs1, rs2, u, rd, 1, stg, 0, 0, f, c);
      if (!f) waited++;
    end
    if (!f) check("offer_timeout", 32'(waited), 32'd0);
  endtask

  initial begin
    bit f, c;
    int w, cyc;
    bus.issue_valid_i = 0; bus.issue_rs1_i = 0; bus.issue_rs2_i = 0;
    bus.issue_uses_rs2_i = 0; bus.issue_rd_i = 0; bus.issue_we_i = 0;
    bus.issue_stages_i = 0; bus.flush_i = 0; bus.downstream_stall_i = 0;
    #1;
    check("por_cnt", 32'(bus.inflight_cnt_o), 32'd0);
    check("por_complete_valid", 32'(bus.complete_valid_o), 32'd0);
    #20 rstn = 1'b1;

    // ADD L=1 rd=5: completes next cycle, table empty after that
    step(1, 1, 2, 1, 5, 1, 1, 0, 0, f, c);
    check("add_fire", 32'(f), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, f, c);
    check("add_complete", 32'(c), 32'd1);
    idle(1);

    // MUL rd=7 then independent ADD: 3 struct-stall cycles
    offer(1, 2, 1, 7, 4, w);
    offer(1, 2, 1, 3, 1, w);
    check("mul_add_wait", 32'(w), 32'd3);
    idle(3);

    // MUL rd=9 then reader of x9
    offer(1, 2, 1, 9, 4, w);
    offer(9, 0, 0, 4, 1, w);
    check("raw_wait", 32'(w), FWD ? 32'd3 : 32'd4);
    idle(3);

    // x0 writer and unused rs2 never cause RAW
    offer(1, 2, 0, 0, 2, w);
    offer(0, 0, 1, 6, 2, w);
    check("x0_wait", 32'(w), 32'd0);
    offer(1, 2, 1, 9, 3, w);
    offer(1, 9, 0, 10, 3, w);
    check("rs2_unused_wait", 32'(w), 32'd0);
    idle(4);

    // Two-cycle freeze delays completion by two
    offer(1, 2, 1, 11, 4, w);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, f, c);
    step(1, 1, 2, 1, 3, 1, 4, 0, 1, f, c);
    check("freeze_fire0", 32'(f), 32'd0);
    step(1, 1, 2, 1, 3, 1, 4, 0, 1, f, c);
    check("freeze_fire1", 32'(f), 32'd0);
    cyc = 3;
    c = 0;
    while (!c && cyc < 12) begin
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, f, c);
      cyc++;
    end
    check("freeze_latency", 32'(cyc), 32'd6);
    idle(2);

    // Flush with a valid offer drops everything including the offer
    offer(1, 2, 1, 12, 2, w);
    offer(1, 2, 1, 13, 3, w);
    step(1, 1, 2, 1, 14, 1, 1, 1, 0, f, c);
    check("flush_fire", 32'(f), 32'd0);
    #2;
    check("flush_cnt", 32'(bus.inflight_cnt_o), 32'd0);

    // Reset mid-MUL
    offer(1, 2, 1, 15, 4, w);
    idle(2);
    do_reset();

    // Random traffic with periodic freezes, flushes and resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4) != 0,
           $urandom_range(0, 7), $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
           f, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
